// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants used by the register file, ALU, selects and
// pipeline registers.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd29;
  localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port: $zero check, write-through bypass, array select.
module reg_read_port
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic [ADDR_W-1:0] rd_reg,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem [NUM_REGS],
  output logic [DATA_W-1:0] rd_data
);

  always_comb begin
    rd_data = mem[rd_reg];
    if (rd_reg == REG_ZERO) begin
      rd_data = '0;
    end else if (wr_en && (wr_reg == rd_reg)) begin
      // Write-through so an instruction reading in the write cycle sees the new value.
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/mips_reg_file.sv
// 32 x 32 MIPS register file: two bypassed combinational read ports, one synchronous write
// port, hardwired $zero and an unbypassed debug read port.
module mips_reg_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Reg_write,
  input  logic [ADDR_W-1:0] Write_reg,
  input  logic [DATA_W-1:0] Write_data,
  input  logic [ADDR_W-1:0] Read_reg_1,
  input  logic [ADDR_W-1:0] Read_reg_2,
  output logic [DATA_W-1:0] Read_data_1,
  output logic [DATA_W-1:0] Read_data_2,
  input  logic [ADDR_W-1:0] Dbg_reg,
  output logic [DATA_W-1:0] Dbg_data
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              byp_en;

  // Reset must also suppress the bypass so reads show 0 while rst is held.
  assign byp_en = Reg_write && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (Reg_write && (Write_reg != REG_ZERO)) begin
      mem_q[Write_reg] <= Write_data;
    end
  end

  reg_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_rd_port_rs (
    .rd_reg (Read_reg_1),
    .wr_en  (byp_en),
    .wr_reg (Write_reg),
    .wr_data(Write_data),
    .mem    (mem_q),
    .rd_data(Read_data_1)
  );

  reg_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_rd_port_rt (
    .rd_reg (Read_reg_2),
    .wr_en  (byp_en),
    .wr_reg (Write_reg),
    .wr_data(Write_data),
    .mem    (mem_q),
    .rd_data(Read_data_2)
  );

  assign Dbg_data = mem_q[Dbg_reg];

endmodule

// File: tb/tb_mips_reg_file.sv
// Randomized and directed bench for mips_reg_file against an array-based reference model.
module tb_mips_reg_file;

  logic        clk;
  logic        rst;
  logic        Reg_write;
  logic [4:0]  Write_reg;
  logic [31:0] Write_data;
  logic [4:0]  Read_reg_1;
  logic [4:0]  Read_reg_2;
  logic [31:0] Read_data_1;
  logic [31:0] Read_data_2;
  logic [4:0]  Dbg_reg;
  logic [31:0] Dbg_data;

  logic [31:0] model [32];
  int unsigned checks;
  int unsigned errors;

  mips_reg_file dut (
    .clk        (clk),
    .rst        (rst),
    .Reg_write  (Reg_write),
    .Write_reg  (Write_reg),
    .Write_data (Write_data),
    .Read_reg_1 (Read_reg_1),
    .Read_reg_2 (Read_reg_2),
    .Read_data_1(Read_data_1),
    .Read_data_2(Read_data_2),
    .Dbg_reg    (Dbg_reg),
    .Dbg_data   (Dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Architectural view: $zero reads 0, a pending write is visible, else stored value.
  function automatic logic [31:0] expect_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (Reg_write === 1'b1 && rst === 1'b0 && Write_reg == idx) return Write_data;
    return model[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Drive one cycle at negedge, check reads before the edge, commit, check debug after.
  task automatic cycle(input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg,
                       input string tag);
    @(negedge clk);
    Reg_write  = we;
    Write_reg  = wreg;
    Write_data = wdata;
    Read_reg_1 = r1;
    Read_reg_2 = r2;
    Dbg_reg    = dbg;
    #1;
    check({tag, ".rd1"}, Read_data_1, expect_read(r1));
    check({tag, ".rd2"}, Read_data_2, expect_read(r2));
    check({tag, ".dbg_pre"}, Dbg_data, model[dbg]);
    @(posedge clk);
    if (we === 1'b1 && wreg != 5'd0) model[wreg] = wdata;
    #1;
    check({tag, ".dbg_post"}, Dbg_data, model[dbg]);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_clear();
    rst        = 1'b1;
    Reg_write  = 1'b0;
    Write_reg  = '0;
    Write_data = '0;
    Read_reg_1 = 5'd5;
    Read_reg_2 = 5'd31;
    Dbg_reg    = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    check("reset.rd1", Read_data_1, 32'h0);
    check("reset.rd2", Read_data_2, 32'h0);
    check("reset.dbg", Dbg_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-cycle after writing R5.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, "w_r5");
    @(negedge clk);
    Reg_write  = 1'b1;
    Write_reg  = 5'd5;
    Write_data = 32'h0BADF00D;
    Read_reg_1 = 5'd5;
    Dbg_reg    = 5'd5;
    #1;
    check("pre_rst.dbg", Dbg_data, 32'hDEADBEEF);
    rst = 1'b1;
    model_clear();
    #1;
    check("async_rst.rd1", Read_data_1, 32'h0);
    check("async_rst.dbg", Dbg_data, 32'h0);
    @(posedge clk);
    #1;
    check("rst_held_write.dbg", Dbg_data, 32'h0);
    check("rst_held_write.rd1", Read_data_1, 32'h0);
    @(negedge clk);
    Reg_write = 1'b0;
    #2;
    rst = 1'b0;

    // Basic writes on consecutive edges, then read back.
    cycle(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd31, 5'd7, "w_r7");
    cycle(1'b1, 5'd31, 32'hFFFFFFFF, 5'd7, 5'd31, 5'd31, "w_r31");
    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd31, 5'd7, "rd_basic");
    check("basic.r7", Read_data_1, 32'h12345678);
    check("basic.r31", Read_data_2, 32'hFFFFFFFF);

    // $zero protection.
    cycle(1'b1, 5'd0, 32'hAAAA5555, 5'd0, 5'd0, 5'd0, "zero_w");
    check("zero.after", Read_data_1, 32'h0);
    check("zero.dbg", Dbg_data, 32'h0);

    // Same-cycle bypass on both ports.
    cycle(1'b1, 5'd9, 32'h1, 5'd1, 5'd2, 5'd9, "w_r9");
    cycle(1'b1, 5'd9, 32'h2, 5'd9, 5'd9, 5'd9, "bypass");
    check("bypass.committed", Dbg_data, 32'h2);

    // Write disabled, including unknown write inputs.
    cycle(1'b0, 5'd3, 32'h55, 5'd3, 5'd3, 5'd3, "wdis");
    check("wdis.r3", Dbg_data, 32'h0);
    cycle(1'b0, 5'bx, 32'hx, 5'd7, 5'd9, 5'd7, "wdis_x");

    // Randomized traffic, reads biased toward the write target to exercise bypass.
    for (int n = 0; n < 300; n++) begin
      logic [4:0] wr;
      logic [4:0] a;
      logic [4:0] b;
      wr = 5'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
      cycle(1'($urandom_range(0, 1)), wr, $urandom, a, b, 5'($urandom), "rand");
    end

    // Full sweep.
    for (int i = 1; i < 32; i++) begin
      cycle(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0, 5'(i), "sweep_w");
    end
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i), "sweep_r");
      check("sweep.rd1", Read_data_1, 32'(i) * 32'h01010101);
      check("sweep.rd2", Read_data_2, 32'(31 - i) * 32'h01010101);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_reg_file.md
Name: mips_reg_file

Overview:
- 32-entry x 32-bit general-purpose register file for the MIPS datapath.
- Sits directly downstream of the write-back 32-bit 2:1 select (MemtoReg). That select's output drives Write_data here.
- Read_data_1 and Read_data_2 feed the ALU operand path, including the ALUSrc 2:1 select.
- Two combinational read ports, one synchronous write port, $zero hardwired. Write-through bypass provides MIPS "write first half, read second half" semantics in a single-edge design.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of architectural registers (must equal 2**ADDR_W)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high; clears every register to 0
- Reg_write  input  1  write enable for the current cycle
- Write_reg  input  ADDR_W  destination register index
- Write_data  input  DATA_W  data from the write-back select
- Read_reg_1  input  ADDR_W  source index rs
- Read_reg_2  input  ADDR_W  source index rt
- Read_data_1  output  DATA_W  contents of rs (bypassed)
- Read_data_2  output  DATA_W  contents of rt (bypassed)
- Dbg_reg  input  ADDR_W  debug/observation index
- Dbg_data  output  DATA_W  contents of Dbg_reg, with no bypass

Behaviour:
- Reset
  - rst high clears all entries to 0 immediately, independent of clk.
  - While rst is high, writes are ignored and all read outputs show 0.
  - rst deasserting mid-cycle gives no write until the next rising edge with rst low.
- Write
  - On a rising clk edge with rst low and Reg_write=1, mem[Write_reg] <= Write_data.
  - Write_reg=0 is discarded; entry 0 never changes.
- Read
  - Reads are purely combinational with zero-cycle latency.
  - Read_data_n = 0 if Read_reg_n=0.
  - Otherwise, if Reg_write=1, rst=0 and Write_reg==Read_reg_n, the output is Write_data (bypass).
  - Otherwise, the output is mem[Read_reg_n].
- Both ports may address the same register; both then return identical values, bypass included.
- Bypass never applies to index 0, even when Reg_write=1 and Write_reg=0.
- Dbg_data returns stored contents only and never the bypass value. It is used by benches to confirm commit after the clock edge.
- Reg_write, Write_reg or Write_data being X/unknown while Reg_write=0 has no effect on state.
- No other internal state exists: no FSM and no pipelining. Storage is a flop array; inference as distributed RAM is permitted only if async reset clearing is preserved.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W=32, ADDR_W=5
  - constant REG_ZERO=5'd0
  - typedef word_t (32-bit) and reg_idx_t (5-bit), reused by the ALU, the 2:1 selects and the pipeline registers
  - named register indices (REG_SP=29, REG_RA=31)
- Sub-module reg_read_port contains the zero-check, bypass compare and array select. It is instantiated twice, for rs and rt.
- The debug port is a plain array index in the top module.

Test Plan:
- Reset clear: pulse rst asynchronously mid-cycle after writing R5=0xDEADBEEF -> Read_data_1 with Read_reg_1=5 goes to 0x00000000 before the next edge; Dbg_data(5)=0.
- Basic write/read: write R7=0x12345678 and R31=0xFFFFFFFF on consecutive edges -> Read_reg_1=7 gives 0x12345678 and Read_reg_2=31 gives 0xFFFFFFFF.
- $zero protection: Reg_write=1, Write_reg=0, Write_data=0xAAAA5555, Read_reg_1=0 -> Read_data_1=0 in that cycle and after the edge; Dbg_data(0)=0.
- Same-cycle bypass: R9 holds 0x1, then Reg_write=1, Write_reg=9, Write_data=0x2, Read_reg_1=Read_reg_2=9 -> both outputs 0x2 before the edge, while Dbg_data(9)=0x1 until the edge and 0x2 after.
- Write disabled: Reg_write=0, Write_reg=3, Write_data=0x55 -> R3 keeps its prior value 0x0, and neither read port shows 0x55.
- Full sweep: write R[i]=i*0x01010101 for i=1..31, read back every index on both ports -> all match; R0 reads 0.
